// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared data-memory map constants plus the arbiter's state and owner-tag encodings.
// MEM_DEPTH is the RAM word-address width; the RAM index is addr[MEM_DEPTH+1:2].
package dmem_arbiter_pkg;
  localparam int MEM_DEPTH = 10;
  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] DMEM_SIZE = 32'h1 << (MEM_DEPTH + 2);
  typedef enum logic {ARB_CPU_PRI, ARB_DMA_FORCE} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} own_t;
endpackage

// File: rtl/dmem_arbiter_streak_ctr.sv
// arb_streak_ctr: saturating count of CPU grants won while DMA waits, flagging when DMA must be forced.
// Ports: clk, rst_n (async active-low), inc (CPU won while DMA waited), clr (streak broken),
//        force_dma (the count reaches MAX_STREAK at the coming edge).
module arb_streak_ctr #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_dma
);
  import dmem_arbiter_pkg::*;
  localparam int W = $clog2(MAX_STREAK + 1);
  logic [W-1:0] cnt, cnt_nxt;
  always_comb cnt_nxt = clr ? '0 : (inc && cnt != W'(MAX_STREAK)) ? cnt + 1'b1 : cnt;
  assign force_dma = cnt_nxt == W'(MAX_STREAK);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU load/store port and the DMA engine.
// Ports: clk, rst_n (async active-low); per requester req/we/addr/wdata in, gnt (combinational),
//        rvalid and rdata out; ram_we/ram_addr/ram_din to the RAM and ram_dout back (1-cycle latency).
module dmem_arbiter #(
  parameter int MEM_DEPTH  = dmem_arbiter_pkg::MEM_DEPTH,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [DATA_W-1:0]    cpu_rdata,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [31:0]          dma_addr,
  input  logic [DATA_W-1:0]    dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [DATA_W-1:0]    dma_rdata,
  output logic                 ram_we,
  output logic [MEM_DEPTH-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_din,
  input  logic [DATA_W-1:0]    ram_dout
);
  import dmem_arbiter_pkg::*;
  arb_state_t state, state_nxt;
  own_t tag_own;
  logic tag_v, cpu_win, force_dma;
  // Byte offset and bits above the RAM index are deliberately ignored (word-aligned, aliased).
  logic unused_addr;
  assign unused_addr = ^{cpu_addr[31:MEM_DEPTH+2], cpu_addr[1:0], dma_addr[31:MEM_DEPTH+2], dma_addr[1:0]};
  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_win = state == ARB_CPU_PRI ? cpu_req : cpu_req && !dma_req;
    cpu_gnt = rst_n && cpu_win;
    dma_gnt = rst_n && dma_req && !cpu_win;
    // DMA_FORCE always lasts one cycle: DMA is either granted or has dropped its request.
    state_nxt = (state == ARB_CPU_PRI && force_dma) ? ARB_DMA_FORCE : ARB_CPU_PRI;
  end
  arb_streak_ctr #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (cpu_gnt && dma_req),
    .clr      (state != ARB_CPU_PRI || dma_gnt || !dma_req),
    .force_dma(force_dma)
  );
  assign ram_we   = cpu_gnt ? cpu_we : dma_gnt && dma_we;
  assign ram_addr = cpu_gnt ? cpu_addr[MEM_DEPTH+1:2] : dma_gnt ? dma_addr[MEM_DEPTH+1:2] : '0;
  assign ram_din  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
  assign cpu_rdata  = ram_dout;
  assign dma_rdata  = ram_dout;
  assign cpu_rvalid = tag_v && tag_own == OWN_CPU;
  assign dma_rvalid = tag_v && tag_own == OWN_DMA;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ARB_CPU_PRI;
      tag_v   <= 1'b0;
      tag_own <= OWN_CPU;
    end else begin
      state   <= state_nxt;
      tag_v   <= (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
      tag_own <= cpu_gnt ? OWN_CPU : OWN_DMA;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU load/store port and a DMA/display-refresh engine.
- Sits between the CPU memory stage and the dataram instance inside the memory subsystem.
- CPU has priority; a starvation counter guarantees the DMA port a slot after a bounded CPU streak.
- Issues single-cycle grants and returns synchronous read data one cycle later, tagged to the owning port.

Parameters:
- MEM_DEPTH, 10: RAM word-address width; RAM index = addr[MEM_DEPTH+1:2].
- DATA_W, 32: data width.
- MAX_STREAK, 4: consecutive CPU grants allowed while dma_req is held before DMA is forced.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid on cpu_rdata
- cpu_rdata  out  DATA_W  read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/32/DATA_W  same as the CPU port
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  same as the CPU port
- ram_we  out  1  RAM write enable
- ram_addr  out  MEM_DEPTH  RAM word index
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid the cycle after address

Behaviour:
- At most one grant per cycle. The granted port's we, addr[MEM_DEPTH+1:2] and wdata drive the RAM combinationally.
- With no grant: ram_we = 0, ram_addr = 0, ram_din = 0.
- State machine, two states:
  - CPU_PRI (reset state): cpu_req wins; DMA is granted only when cpu_req = 0.
  - DMA_FORCE: dma_req wins; CPU is granted only when dma_req = 0.
- streak counter (width clog2(MAX_STREAK+1)), in CPU_PRI only:
  - Increments on a cycle with cpu_gnt = 1 and dma_req = 1.
  - Clears on any dma_gnt, or on any cycle with dma_req = 0.
  - When streak reaches MAX_STREAK at the clock edge, the next state is DMA_FORCE.
- DMA_FORCE returns to CPU_PRI after one dma_gnt, or if dma_req drops. Either way, streak clears.
- Read return:
  - Registered owner tag captures {valid, port} on each read grant.
  - The next cycle, the owner's rvalid = 1 for exactly one cycle.
  - cpu_rdata = dma_rdata = ram_dout at all times; consumers qualify with rvalid.
  - Writes never produce rvalid.
- Back-to-back reads from alternating ports each return on their own port, one cycle after grant. Read latency is fixed at 1.
- Address bits [1:0] and bits above MEM_DEPTH+1 are ignored: accesses are word-aligned and aliased.
- Simultaneous requests on the same cycle are resolved by state only. The losing request must be held by its requester; no internal queue.
- Reset (asynchronous, any time):
  - State goes to CPU_PRI, streak to 0, owner tag to invalid, so both rvalid = 0.
  - Both gnt and ram_we are forced to 0 while rst_n = 0.
  - A read granted in the cycle before reset returns no rvalid.

Decomposition:
- Shared package/defines file holds the state encodings (ARB_CPU_PRI, ARB_DMA_FORCE), the owner tag encodings (OWN_CPU, OWN_DMA) and MEM_DEPTH, alongside the existing memory-map defines.
- One natural sub-module, arb_streak_ctr: the saturating streak counter plus its force-threshold compare.
- Grant mux and return tagging stay in the top.

Test Plan:
- Reset: rst_n low mid-read (cpu read of 0x10 granted in the previous cycle) -> cpu_rvalid = 0, both gnt = 0, ram_we = 0 while rst_n low; first post-reset dma_req alone is granted.
- CPU write then read: cpu write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0040 -> ram_addr = 16 on both cycles; cpu_rvalid = 1 one cycle after the read grant with cpu_rdata = 0xDEADBEEF; dma_rvalid = 0 throughout.
- Contention: cpu_req and dma_req held high continuously -> grant sequence CPU, CPU, CPU, CPU, DMA, CPU, CPU, CPU, CPU, DMA, ... (MAX_STREAK = 4).
- Streak clear: cpu_req held high; dma_req high for 3 cycles, low for 1 cycle, then high again -> no forced DMA slot until 4 further consecutive CPU grants.
- Interleaved return: cpu read 0x8 in cycle N, dma read 0xC in cycle N+1 (cpu_req low) -> cpu_rvalid in N+1 with RAM word 2, dma_rvalid in N+2 with RAM word 3, never both high together.
- Aliasing: dma write 0x1234 to 0x0000_1004 with MEM_DEPTH = 10 -> ram_addr = 1; a cpu read of 0x0000_0004 returns 0x1234.
